// File: rtl/imm_pkg.sv
// Shared widths, limits and the buffered result type for the immediate packer.
package imm_pkg;

   localparam int unsigned IMM_W  = 21;
   localparam int unsigned DATA_W = 32;

   localparam logic [IMM_W-1:0] IMM_MAX = 21'h0FFFFF;
   localparam logic [IMM_W-1:0] IMM_MIN = 21'h100000;

   // One packed result: immediate field plus its overflow flag.
   typedef struct packed {
      logic [IMM_W-1:0] imm;
      logic             ovf;
   } imm_res_t;

endpackage

// File: rtl/imm_fit_check.sv
// Combinational 21-bit fit test and pack of a 32-bit signed value.
// IMM_PACK_SAT_EN: when defined, non-fitting values clamp to IMM_MAX/IMM_MIN
// instead of being truncated.
module imm_fit_check
   import imm_pkg::*;
(
   input  logic [DATA_W-1:0] i_val,
   output imm_res_t          o_res_c
);

   logic w_fit;

   // Fits iff the upper 12 bits are a pure sign extension of bit 20.
   always_comb begin
      w_fit = (&i_val[DATA_W-1:IMM_W-1]) | ~(|i_val[DATA_W-1:IMM_W-1]);
      o_res_c.ovf = ~w_fit;
`ifdef IMM_PACK_SAT_EN
      if (w_fit) begin
         o_res_c.imm = i_val[IMM_W-1:0];
      end else if (i_val[DATA_W-1]) begin
         o_res_c.imm = IMM_MIN;
      end else begin
         o_res_c.imm = IMM_MAX;
      end
`else
      o_res_c.imm = i_val[IMM_W-1:0];
`endif
   end

endmodule

// File: rtl/imm_pack.sv
// Streams 32-bit signed values into 21-bit immediates through a 2-entry
// output skid buffer, with sticky and saturating-count overflow status.
// IMM_PACK_SAT_EN: saturate non-fitting values (see imm_fit_check).
module imm_pack
   import imm_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_val,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IMM_W-1:0]  out_imm,
   output logic              out_ovf,
   input  logic              clr_ovf,
   output logic              ovf_sticky,
   output logic [CNT_W-1:0]  ovf_count
);

   imm_res_t         w_res;
   imm_res_t         r_out;
   imm_res_t         r_skid;
   imm_res_t         w_out_nxt;
   imm_res_t         w_skid_nxt;
   logic             r_out_valid;
   logic             r_skid_full;
   logic             r_in_ready;
   logic             w_out_valid_nxt;
   logic             w_skid_full_nxt;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_ovf_evt;
   logic             r_sticky;
   logic [CNT_W-1:0] r_count;
   logic             w_sticky_nxt;
   logic [CNT_W-1:0] w_count_nxt;

   imm_fit_check u_fit (
      .i_val   (in_val),
      .o_res_c (w_res)
   );

   assign w_in_xfer  = in_valid & r_in_ready;
   assign w_out_xfer = r_out_valid & out_ready;
   assign w_ovf_evt  = w_in_xfer & w_res.ovf;

   // Skid buffer next state: refill OUT from input or SKID, park in SKID when stalled.
   always_comb begin
      w_out_nxt       = r_out;
      w_out_valid_nxt = r_out_valid;
      w_skid_nxt      = r_skid;
      w_skid_full_nxt = r_skid_full;
      if (!r_out_valid || (w_out_xfer && !r_skid_full)) begin
         if (w_in_xfer) begin
            w_out_nxt       = w_res;
            w_out_valid_nxt = 1'b1;
         end else begin
            w_out_valid_nxt = 1'b0;
         end
      end else if (!w_out_xfer) begin
         if (w_in_xfer) begin
            w_skid_nxt      = w_res;
            w_skid_full_nxt = 1'b1;
         end
      end else begin
         // SKID full implies in_ready=0, so no new value competes here.
         w_out_nxt       = r_skid;
         w_skid_full_nxt = 1'b0;
      end
   end

   // Overflow status next state; a new event takes priority over a clear.
   always_comb begin
      w_sticky_nxt = r_sticky;
      w_count_nxt  = r_count;
      if (w_ovf_evt) begin
         w_sticky_nxt = 1'b1;
         if (clr_ovf) begin
            w_count_nxt = CNT_W'(1);
         end else if (!(&r_count)) begin
            w_count_nxt = r_count + CNT_W'(1);
         end
      end else if (clr_ovf) begin
         w_sticky_nxt = 1'b0;
         w_count_nxt  = '0;
      end
   end

   // Buffer and status registers; in_ready tracks the next SKID occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out       <= '0;
         r_skid      <= '0;
         r_out_valid <= 1'b0;
         r_skid_full <= 1'b0;
         r_in_ready  <= 1'b1;
         r_sticky    <= 1'b0;
         r_count     <= '0;
      end else begin
         r_out       <= w_out_nxt;
         r_skid      <= w_skid_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_skid_full <= w_skid_full_nxt;
         r_in_ready  <= ~w_skid_full_nxt;
         r_sticky    <= w_sticky_nxt;
         r_count     <= w_count_nxt;
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_imm    = r_out.imm;
   assign out_ovf    = r_out.ovf;
   assign ovf_sticky = r_sticky;
   assign ovf_count  = r_count;

endmodule

// File: tb/tb_imm_pack.sv
// Directed plus random bench for imm_pack with a queue-based reference model.
module tb_imm_pack;

   localparam int unsigned TB_CNT_W = 6;
   localparam logic [TB_CNT_W-1:0] CNT_MAX = '1;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_val;
   logic                out_valid;
   logic                out_ready;
   logic [20:0]         out_imm;
   logic                out_ovf;
   logic                clr_ovf;
   logic                ovf_sticky;
   logic [TB_CNT_W-1:0] ovf_count;

   int tests = 0;
   int fails = 0;

   logic [21:0]         q[$];      // {ovf, imm} in acceptance order
   logic                m_sticky;
   logic [TB_CNT_W-1:0] m_count;

   imm_pack #(.CNT_W(TB_CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_val     (in_val),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_imm    (out_imm),
      .out_ovf    (out_ovf),
      .clr_ovf    (clr_ovf),
      .ovf_sticky (ovf_sticky),
      .ovf_count  (ovf_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: fits iff value lies in [-2^20, 2^20-1].
   function automatic logic [21:0] model(input logic [31:0] v);
      longint s;
      logic   fits;
      logic [20:0] imm;
      s    = longint'($signed(v));
      fits = (s >= -64'sd1048576) && (s <= 64'sd1048575);
      imm  = v[20:0];
`ifdef IMM_PACK_SAT_EN
      if (!fits) imm = (s < 0) ? 21'h100000 : 21'h0FFFFF;
`endif
      return {~fits, imm};
   endfunction

   // Check visible state against the model, then advance one clock.
   task automatic cycle();
      logic        ix, ox;
      logic [21:0] e;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
      chk("ovf_count", 32'(ovf_count), 32'(m_count));
      ix = in_valid && in_ready;
      ox = out_valid && out_ready;
      if (ox && q.size() > 0) begin
         e = q.pop_front();
         chk("out_imm", 32'(out_imm), 32'(e[20:0]));
         chk("out_ovf", 32'(out_ovf), 32'(e[21]));
      end
      if (ix) begin
         e = model(in_val);
         q.push_back(e);
      end
      if (ix && e[21]) begin
         m_sticky = 1'b1;
         if (clr_ovf) m_count = TB_CNT_W'(1);
         else if (m_count != CNT_MAX) m_count = m_count + TB_CNT_W'(1);
      end else if (clr_ovf) begin
         m_sticky = 1'b0;
         m_count  = '0;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_val();
      logic [31:0] edges [8];
      logic [31:0] x;
      edges = '{32'h000FFFFF, 32'hFFF00000, 32'h00100000, 32'hFFEFFFFF,
                32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
      x = $urandom;
      case ($urandom_range(0, 2))
         0:       return x;
         1:       return {{11{x[20]}}, x[20:0]};
         default: return edges[$urandom_range(0, 7)];
      endcase
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_val = '0; out_ready = 1'b0; clr_ovf = 1'b0;
      m_sticky = 1'b0; m_count = '0;
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_imm", 32'(out_imm), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      chk("rst_sticky", 32'(ovf_sticky), 32'd0);
      chk("rst_count", 32'(ovf_count), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Single values: max positive, min negative, first overflow.
      out_ready = 1'b1;
      in_valid = 1'b1; in_val = 32'h000FFFFF; cycle();
      in_valid = 1'b0;
      chk("lat1_imm", 32'(out_imm), 32'h000FFFFF);
      chk("lat1_ovf", 32'(out_ovf), 32'd0);
      cycle();
      in_valid = 1'b1; in_val = 32'hFFF00000; cycle();
      in_valid = 1'b0;
      chk("min_imm", 32'(out_imm), 32'h00100000);
      cycle();
      in_valid = 1'b1; in_val = 32'h00100000; cycle();
      in_valid = 1'b0;
`ifdef IMM_PACK_SAT_EN
      chk("ovf_imm", 32'(out_imm), 32'h000FFFFF);
`else
      chk("ovf_imm", 32'(out_imm), 32'h00100000);
`endif
      chk("ovf_flag", 32'(out_ovf), 32'd1);
      chk("ovf_sticky1", 32'(ovf_sticky), 32'd1);
      chk("ovf_count1", 32'(ovf_count), 32'd1);
      cycle();

      // Back-pressure: 5,6,7 with out_ready low; 7 waits until a slot frees.
      out_ready = 1'b0;
      in_valid = 1'b1; in_val = 32'd5; cycle();
      in_val = 32'd6; cycle();
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      in_val = 32'd7; cycle(); cycle();
      out_ready = 1'b1; cycle();
      chk("bp_in_ready_back", 32'(in_ready), 32'd1);
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      chk("bp_drained", 32'(q.size()), 32'd0);

      // Full throughput: 100 back-to-back random values.
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_val = rand_val();
         cycle();
      end
      in_valid = 1'b0;
      cycle(); cycle();

      // Random valid/ready traffic.
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 3) != 0);
         in_val    = rand_val();
         clr_ovf   = 1'($urandom_range(0, 15) == 0);
         cycle();
      end
      in_valid = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
      cycle(); cycle(); cycle();

      // Clear alone, then clear coinciding with an overflow acceptance.
      in_valid = 1'b1; in_val = 32'h80000000; cycle();
      in_valid = 1'b0; clr_ovf = 1'b1; cycle();
      clr_ovf = 1'b0;
      chk("clr_sticky", 32'(ovf_sticky), 32'd0);
      chk("clr_count", 32'(ovf_count), 32'd0);
      in_valid = 1'b1; in_val = 32'hFFF00000; cycle();
      in_val = 32'h40000000; cycle();
      in_valid = 1'b1; in_val = 32'h00200000; clr_ovf = 1'b1; cycle();
      clr_ovf = 1'b0; in_valid = 1'b0;
      chk("clr_evt_sticky", 32'(ovf_sticky), 32'd1);
      chk("clr_evt_count", 32'(ovf_count), 32'd1);
      cycle(); cycle();

      // Saturation: drive past all-ones.
      in_valid = 1'b1;
      for (int i = 0; i < 70; i++) begin
         in_val = ($urandom_range(0, 1) != 0) ? 32'hF0000000 : 32'h0FFFFFFF;
         cycle();
      end
      in_valid = 1'b0;
      chk("sat_count", 32'(ovf_count), 32'(CNT_MAX));
      cycle(); cycle();

      // Asynchronous reset with both slots full.
      out_ready = 1'b0; in_valid = 1'b1;
      in_val = 32'h00000123; cycle();
      in_val = 32'h7FFFFFFF; cycle();
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_sticky", 32'(ovf_sticky), 32'd0);
      chk("arst_count", 32'(ovf_count), 32'd0);
      chk("arst_out_imm", 32'(out_imm), 32'd0);
      q.delete();
      m_sticky = 1'b0; m_count = '0;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      cycle(); cycle();
      in_valid = 1'b1; in_val = 32'hFFFFFFFE; cycle();
      in_valid = 1'b0; cycle(); cycle();
      chk("final_empty", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
